// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM bus arbiter handing the command/address/bank bus to init, refresh, write or read (inputs: per-owner req/end flags and cmd/addr/bank; outputs: ref_en/wr_en/rd_en grant pulses, muxed sdram_cmd/addr/bank, arb_state); define ARBIT_RR_EN for write/read round robin
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_req,
  input  logic        flag_ref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  output logic        ref_en,
  input  logic        wr_req,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [2:0]  arb_state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARBIT = 3'd1, AREF = 3'd2, WRITE = 3'd3, READ = 3'd4} state_t;
  state_t r_state, w_nxt;
  logic   r_ref_en, r_wr_en, r_rd_en;
  logic   w_ref_g, w_wr_g, w_rd_g, w_wr_wins;
`ifdef ARBIT_RR_EN
  logic   r_last_rd;
  assign w_wr_wins = r_last_rd;
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) r_last_rd <= 1'b1;
    else if (w_wr_g | w_rd_g) r_last_rd <= w_rd_g;
`else
  assign w_wr_wins = 1'b1;
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:  w_nxt = flag_init_end ? ARBIT : IDLE;
      ARBIT: w_nxt = ref_req ? AREF :
                     (wr_req && rd_req) ? (w_wr_wins ? WRITE : READ) :
                     wr_req ? WRITE : rd_req ? READ : ARBIT;
      AREF:  w_nxt = flag_ref_end ? ARBIT : AREF;
      WRITE: w_nxt = flag_wr_end ? ARBIT : WRITE;
      READ:  w_nxt = flag_rd_end ? ARBIT : READ;
      default: w_nxt = IDLE;
    endcase
  end
  assign w_ref_g = (r_state == ARBIT) && (w_nxt == AREF);
  assign w_wr_g  = (r_state == ARBIT) && (w_nxt == WRITE);
  assign w_rd_g  = (r_state == ARBIT) && (w_nxt == READ);
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      r_state  <= IDLE;
      r_ref_en <= 1'b0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_ref_en <= w_ref_g;
      r_wr_en  <= w_wr_g;
      r_rd_en  <= w_rd_g;
    end
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = 12'd0;
    sdram_bank = 2'd0;
    case (r_state)
      IDLE:  begin sdram_cmd = init_cmd; sdram_addr = init_addr; end
      AREF:  begin sdram_cmd = aref_cmd; sdram_addr = aref_addr; end
      WRITE: begin sdram_cmd = wr_cmd; sdram_addr = wr_addr; sdram_bank = wr_bank; end
      READ:  begin sdram_cmd = rd_cmd; sdram_addr = rd_addr; sdram_bank = rd_bank; end
      default: ;
    endcase
  end
  assign ref_en    = r_ref_en;
  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign arb_state = r_state;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed self-checking bench for sdram_arbit
module tb_sdram_arbit;
  logic        sclk = 1'b0, s_rst_n = 1'b0;
  logic        flag_init_end = 1'b0;
  logic [3:0]  init_cmd = 4'hA;
  logic [11:0] init_addr = 12'h123;
  logic        ref_req = 1'b0, flag_ref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'h1;
  logic [11:0] aref_addr = 12'h400;
  logic        wr_req = 1'b0, flag_wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'h4;
  logic [11:0] wr_addr = 12'h555;
  logic [1:0]  wr_bank = 2'd2;
  logic        rd_req = 1'b0, flag_rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'h5;
  logic [11:0] rd_addr = 12'h0AA;
  logic [1:0]  rd_bank = 2'd3;
  logic        ref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [2:0]  arb_state;
  int total = 0, bad = 0;
`ifdef ARBIT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  sdram_arbit dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr), .ref_en(ref_en),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_en(wr_en),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank), .arb_state(arb_state)
  );
  always #5 sclk = ~sclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask
  task automatic chk_en(input string tag, input logic r, input logic w, input logic d);
    chk({tag, "_ref_en"}, 32'(ref_en), 32'(r));
    chk({tag, "_wr_en"}, 32'(wr_en), 32'(w));
    chk({tag, "_rd_en"}, 32'(rd_en), 32'(d));
  endtask
  initial begin
    logic exp_w;
    #3;
    chk("rst_state", 32'(arb_state), 0);
    chk_en("rst", 1'b0, 1'b0, 1'b0);
    s_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_state", 32'(arb_state), 0);
    end
    chk("idle_cmd", 32'(sdram_cmd), 32'hA);
    chk("idle_addr", 32'(sdram_addr), 32'h123);
    chk("idle_bank", 32'(sdram_bank), 0);
    flag_init_end = 1'b1;
    tick();
    chk("arbit_state", 32'(arb_state), 1);
    chk("arbit_cmd", 32'(sdram_cmd), 32'h7);
    chk("arbit_addr", 32'(sdram_addr), 0);
    chk("arbit_bank", 32'(sdram_bank), 0);
    tick();
    chk("arbit_hold", 32'(arb_state), 1);
    chk_en("arbit_hold", 1'b0, 1'b0, 1'b0);
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    chk("aref_state", 32'(arb_state), 2);
    chk_en("aref_grant", 1'b1, 1'b0, 1'b0);
    chk("aref_cmd", 32'(sdram_cmd), 32'h1);
    chk("aref_addr", 32'(sdram_addr), 32'h400);
    ref_req = 1'b0;
    tick();
    chk_en("aref_pulse", 1'b0, 1'b0, 1'b0);
    chk("aref_stay", 32'(arb_state), 2);
    flag_ref_end = 1'b1;
    tick();
    flag_ref_end = 1'b0;
    chk("aref_end", 32'(arb_state), 1);
    chk_en("aref_end", 1'b0, 1'b0, 1'b0);
    tick();
    chk("wr_state", 32'(arb_state), 3);
    chk_en("wr_grant", 1'b0, 1'b1, 1'b0);
    chk("wr_cmd", 32'(sdram_cmd), 32'h4);
    chk("wr_addr", 32'(sdram_addr), 32'h555);
    chk("wr_bank", 32'(sdram_bank), 2);
    wr_req = 1'b0;
    flag_rd_end = 1'b1;
    tick();
    tick();
    chk("wr_ignore_rd_end", 32'(arb_state), 3);
    flag_rd_end = 1'b0;
    ref_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wr_no_preempt", 32'(arb_state), 3);
      chk("wr_no_ref_en", 32'(ref_en), 0);
    end
    flag_wr_end = 1'b1;
    tick();
    flag_wr_end = 1'b0;
    chk("wr_end", 32'(arb_state), 1);
    tick();
    chk("ref_after_wr", 32'(arb_state), 2);
    chk_en("ref_after_wr", 1'b1, 1'b0, 1'b0);
    ref_req = 1'b0;
    flag_ref_end = 1'b1;
    tick();
    flag_ref_end = 1'b0;
    chk("aref_end2", 32'(arb_state), 1);
    tick();
    chk("rd_state", 32'(arb_state), 4);
    chk_en("rd_grant", 1'b0, 1'b0, 1'b1);
    chk("rd_cmd", 32'(sdram_cmd), 32'h5);
    chk("rd_addr", 32'(sdram_addr), 32'h0AA);
    chk("rd_bank", 32'(sdram_bank), 3);
    rd_req = 1'b0;
    flag_wr_end = 1'b1;
    tick();
    flag_wr_end = 1'b0;
    chk("rd_ignore_wr_end", 32'(arb_state), 4);
    chk_en("rd_pulse", 1'b0, 1'b0, 1'b0);
    flag_rd_end = 1'b1;
    tick();
    flag_rd_end = 1'b0;
    chk("rd_end", 32'(arb_state), 1);
    rd_req = 1'b1;
    tick();
    chk("rd2_state", 32'(arb_state), 4);
    chk("rd2_en", 32'(rd_en), 1);
    rd_req = 1'b0;
    flag_init_end = 1'b0;
    #2 s_rst_n = 1'b0;
    #1;
    chk("rst_mid_state", 32'(arb_state), 0);
    chk("rst_mid_rd_en", 32'(rd_en), 0);
    chk("rst_mid_cmd", 32'(sdram_cmd), 32'hA);
    chk("rst_mid_addr", 32'(sdram_addr), 32'h123);
    chk("rst_mid_bank", 32'(sdram_bank), 0);
    tick();
    chk("rst_hold", 32'(arb_state), 0);
    s_rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(arb_state), 0);
    chk_en("post_rst", 1'b0, 1'b0, 1'b0);
    flag_init_end = 1'b1;
    tick();
    chk("post_rst_arbit", 32'(arb_state), 1);
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w = RR ? (i % 2 == 0) : 1'b1;
      tick();
      chk("tie_state", 32'(arb_state), exp_w ? 3 : 4);
      chk_en("tie_grant", 1'b0, exp_w, !exp_w);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk_en("tie_busy", 1'b0, 1'b0, 1'b0);
      end
      flag_wr_end = 1'b1; flag_rd_end = 1'b1;
      tick();
      flag_wr_end = 1'b0; flag_rd_end = 1'b0;
      chk("tie_end", 32'(arb_state), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter: CMD_NOP, default 4'b0111, NOP command driven while no owner holds the bus.
REQ-002 Port: sclk  in  1  system clock; all state changes on the rising edge.
REQ-003 Port: s_rst_n  in  1  asynchronous active-low reset.
REQ-004 Ports: flag_init_end in 1 (init complete); init_cmd in 4; init_addr in 12.
REQ-005 Ports: ref_req in 1; flag_ref_end in 1; aref_cmd in 4; aref_addr in 12; ref_en out 1 (refresh grant pulse).
REQ-006 Ports: wr_req in 1; flag_wr_end in 1; wr_cmd in 4; wr_addr in 12; wr_bank in 2; wr_en out 1 (write grant pulse).
REQ-007 Ports: rd_req in 1; flag_rd_end in 1; rd_cmd in 4; rd_addr in 12; rd_bank in 2; rd_en out 1 (read grant pulse).
REQ-008 Ports: sdram_cmd out 4; sdram_addr out 12; sdram_bank out 2; arb_state out 3 (current state, debug).

Function
REQ-009 States: IDLE=0, ARBIT=1, AREF=2, WRITE=3, READ=4; registered state, no other encodings reachable.
REQ-010 IDLE -> ARBIT on the first edge with flag_init_end=1; never re-enters IDLE except by reset.
REQ-011 ARBIT priority, fixed build: ref_req > wr_req > rd_req; no request -> stay ARBIT.
REQ-012 Grant: on the ARBIT->X edge, the matching en output goes high for exactly one cycle (first cycle of X); all other cycles en=0.
REQ-013 At most one of ref_en/wr_en/rd_en high in any cycle.
REQ-014 AREF -> ARBIT on edge with flag_ref_end=1; WRITE -> ARBIT on flag_wr_end=1; READ -> ARBIT on flag_rd_end=1.
REQ-015 End flags not matching the current state are ignored.
REQ-016 Minimum one ARBIT cycle between any two owners; a request pending at end-of-op is granted on the following edge.
REQ-017 Requests are level; requester holds req until its en pulse; req dropped before grant -> no grant.
REQ-018 ref_req rising during WRITE/READ does not preempt; it wins at the next ARBIT cycle.
REQ-019 Bus mux (combinational on state): IDLE -> init_cmd/init_addr/bank 0; AREF -> aref_cmd/aref_addr/bank 0; WRITE -> wr_cmd/wr_addr/wr_bank; READ -> rd_cmd/rd_addr/rd_bank; ARBIT -> CMD_NOP/12'd0/2'd0.
REQ-020 Widths fixed as listed; no truncation or extension in the mux.

Reset
REQ-021 s_rst_n=0 asynchronously forces state=IDLE, ref_en=wr_en=rd_en=0, round-robin pointer=READ-last.
REQ-022 Reset mid-operation abandons the owner with no end handshake; bus immediately follows IDLE mux (init_cmd/init_addr).
REQ-023 After release, behaviour identical to power-up; no pending grant survives.

Configuration
REQ-024 Macro ARBIT_RR_EN defined: wr_req and rd_req both pending in ARBIT (no ref_req) -> grant the one not granted last; pointer updates on each wr_en/rd_en; first tie after reset goes to write.
REQ-025 ARBIT_RR_EN undefined: write always beats read; pointer logic absent; refresh highest in both builds.

Verification
REQ-026 Reset, flag_init_end=0 for 20 cycles -> state=0, sdram_cmd=init_cmd; flag_init_end=1 -> state=1 next edge, sdram_cmd=4'b0111.
REQ-027 ref_req, wr_req, rd_req all high in ARBIT -> ref_en single pulse, state=2, sdram_cmd=aref_cmd; flag_ref_end -> ARBIT one cycle -> wr_en pulse, state=3.
REQ-028 Write active, ref_req rises, flag_wr_end 10 cycles later -> no preemption; ARBIT then AREF with ref_en pulse.
REQ-029 ARBIT_RR_EN defined, wr_req and rd_req held high, end flags 4 cycles after each grant -> grants alternate W,R,W,R; undefined -> W,W,W,W.
REQ-030 s_rst_n pulsed low during READ -> state=0, rd_en=0 same cycle, sdram_cmd=init_cmd, sdram_bank=0.
REQ-031 flag_rd_end asserted while in WRITE -> ignored, state stays 3 until flag_wr_end.
